// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
// Holds the SUB mode encoding, the stage-count helper and the
// WIDTH/SEG legality check used at elaboration of adder_pipe.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of pipeline stages for a given operand width and segment size.
  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

  // WIDTH must be a positive whole multiple of SEG.
  function automatic bit seg_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple-carry full-adder chain.
// Ports: a, b (segment operands), ci (carry in) -> s (segment sum), co (carry out).
// No state; one instance per pipeline stage in adder_pipe.
module adder_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  always_comb begin
    logic c;
    s = '0;
    c = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder/subtractor, one SEG-bit segment per stage,
// valid/ready handshake, latency STAGES, one beat per cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with in0 (A), in1 (B),
// cin, sub; out_valid/out_ready with sum, cout, ovf, zero.
// Global stall when out_valid && !out_ready: every stage holds, in_ready drops.
// Define ADDER_PIPE_FLAGS_EN to build the ovf/zero flag registers; otherwise
// both flags are tied to 0.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  if (!seg_ok(WIDTH, SEG)) begin : g_cfg_check
    $error("adder_pipe: WIDTH must be a positive multiple of SEG");
  end

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is A + ~B + 1; the external carry-in is ignored then.
  assign b_eff   = (sub == MODE_SUB) ? ~in1 : in1;
  assign cin_eff = (sub == MODE_SUB) ? 1'b1 : cin;

  assign stall    = g_stage[STAGES-1].v_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Stage k resolves segment k. The word register w_q carries the finished
  // low sum segments and the still-pending upper A segments in one vector;
  // b_in only keeps the B segments not yet consumed.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int BW = WIDTH - LO;

    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] w_in;
    logic [BW-1:0]    b_in;
    logic [SEG-1:0]   seg_sum;
    logic             seg_co;
    logic [WIDTH-1:0] w_nxt;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] w_q;

    if (k == 0) begin : g_head
      assign v_in = accept;
      assign c_in = cin_eff;
      assign w_in = in0;
      assign b_in = b_eff;
    end else begin : g_body
      assign v_in = g_stage[k-1].v_q;
      assign c_in = g_stage[k-1].c_q;
      assign w_in = g_stage[k-1].w_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a  (w_in[LO +: SEG]),
      .b  (b_in[SEG-1:0]),
      .ci (c_in),
      .s  (seg_sum),
      .co (seg_co)
    );

    always_comb begin
      w_nxt           = w_in;
      w_nxt[LO +: SEG] = seg_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        w_q <= '0;
      end else if (!stall) begin
        v_q <= v_in;
        c_q <= seg_co;
        w_q <= w_nxt;
      end
    end

    // Upper B segments skew forward; the last stage has nothing left to pass.
    if (k < STAGES - 1) begin : g_fwd
      logic [BW-SEG-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q <= '0;
        end else if (!stall) begin
          b_q <= b_in[BW-1:SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].w_q;
  assign cout      = g_stage[STAGES-1].c_q;

`ifdef ADDER_PIPE_FLAGS_EN
  // The operand sign bits reach the last stage inside the skewed A word and
  // the remaining B segment, so overflow is resolved there and registered
  // together with the final sum.
  logic a_msb, b_msb, s_msb;
  logic ovf_nxt, zero_nxt;
  logic ovf_q, zero_q;

  assign a_msb    = g_stage[STAGES-1].w_in[WIDTH-1];
  assign b_msb    = g_stage[STAGES-1].b_in[SEG-1];
  assign s_msb    = g_stage[STAGES-1].seg_sum[SEG-1];
  assign ovf_nxt  = (a_msb == b_msb) && (s_msb != a_msb);
  assign zero_nxt = ~|g_stage[STAGES-1].w_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      ovf_q  <= ovf_nxt;
      zero_q <= zero_nxt;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule
